// File: rtl/alu_arbiter.sv
// Two-requester round-robin front end for a shared external combinational ALU.
// Each operation is accepted in IDLE, issued for one cycle, and held in RESP until consumed.
module alu_arbiter #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [3:0]       req0_opcode,
    input  logic [3:0]       req0_a,
    input  logic [3:0]       req0_b,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [3:0]       req1_opcode,
    input  logic [3:0]       req1_a,
    input  logic [3:0]       req1_b,
    output logic             rsp0_valid,
    input  logic             rsp0_ready,
    output logic             rsp1_valid,
    input  logic             rsp1_ready,
    output logic [3:0]       rsp_data,
    output logic [3:0]       rsp_flags,
    output logic             rsp_err,
    output logic [3:0]       alu_a,
    output logic [3:0]       alu_b,
    output logic [3:0]       alu_opcode,
    output logic             alu_enable,
    input  logic [3:0]       alu_result,
    input  logic [3:0]       alu_flags,
    output logic             busy,
    output logic [CNT_W-1:0] cnt0,
    output logic [CNT_W-1:0] cnt1
);

    typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

    state_t     state, state_nxt;
    logic       ptr;
    logic       any_req;
    logic       grant_sel;
    logic       rsp_done;
    logic       gid_p0;
    logic [3:0] op_p0, a_p0, b_p0;
    logic [3:0] res_p1, flg_p1;
    logic       err_p1;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    function automatic logic bad_opcode(input logic [3:0] op);
        return op > 4'd10;
    endfunction

    // With a single requester the pointer is irrelevant; it only breaks ties.
    always_comb begin
        any_req   = req0_valid | req1_valid;
        grant_sel = (req0_valid & req1_valid) ? ptr : req1_valid;
        rsp_done  = (state == RESP) && (gid_p0 ? rsp1_ready : rsp0_ready);
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt  = state;
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        alu_enable = 1'b0;
        alu_a      = 4'd0;
        alu_b      = 4'd0;
        alu_opcode = 4'd0;
        rsp0_valid = 1'b0;
        rsp1_valid = 1'b0;
        case (state)
            IDLE: begin
                if (any_req) begin
                    req0_ready = ~grant_sel;
                    req1_ready = grant_sel;
                    state_nxt  = ISSUE;
                end
            end
            ISSUE: begin
                alu_enable = 1'b1;
                alu_a      = a_p0;
                alu_b      = b_p0;
                alu_opcode = op_p0;
                state_nxt  = RESP;
            end
            RESP: begin
                rsp0_valid = ~gid_p0;
                rsp1_valid = gid_p0;
                if (rsp_done) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Accept stage: capture the granted request
    always_ff @(posedge clk) begin
        if (rst) begin
            gid_p0 <= 1'b0;
            op_p0  <= 4'd0;
            a_p0   <= 4'd0;
            b_p0   <= 4'd0;
        end else if (state == IDLE && any_req) begin
            gid_p0 <= grant_sel;
            op_p0  <= grant_sel ? req1_opcode : req0_opcode;
            a_p0   <= grant_sel ? req1_a : req0_a;
            b_p0   <= grant_sel ? req1_b : req0_b;
        end
    end

    // Issue stage: register the ALU outcome, overriding it for illegal opcodes
    always_ff @(posedge clk) begin
        if (rst) begin
            res_p1 <= 4'd0;
            flg_p1 <= 4'd0;
            err_p1 <= 1'b0;
        end else if (state == ISSUE) begin
            res_p1 <= bad_opcode(op_p0) ? 4'd0 : alu_result;
            flg_p1 <= bad_opcode(op_p0) ? 4'b1000 : alu_flags;
            err_p1 <= bad_opcode(op_p0);
        end
    end

    // Completion: hand priority to the other requester and count the operation
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr  <= 1'b0;
            cnt0 <= '0;
            cnt1 <= '0;
        end else if (rsp_done) begin
            ptr <= ~gid_p0;
            if (gid_p0) cnt1 <= sat_inc(cnt1);
            else        cnt0 <= sat_inc(cnt0);
        end
    end

    assign busy      = (state != IDLE);
    assign rsp_data  = res_p1;
    assign rsp_flags = flg_p1;
    assign rsp_err   = err_p1;

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: external ALU model, response scoreboard, vector table
// and hand-written sequences for arbitration, back-pressure, reset and saturation.
module tb_alu_arbiter;

    localparam int CNT_W = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic req0_valid = 1'b0, req1_valid = 1'b0;
    logic req0_ready, req1_ready;
    logic [3:0] req0_opcode = '0, req0_a = '0, req0_b = '0;
    logic [3:0] req1_opcode = '0, req1_a = '0, req1_b = '0;
    logic rsp0_valid, rsp1_valid;
    logic rsp0_ready = 1'b1, rsp1_ready = 1'b1;
    logic [3:0] rsp_data, rsp_flags;
    logic rsp_err;
    logic [3:0] alu_a, alu_b, alu_opcode;
    logic alu_enable;
    logic [3:0] alu_result, alu_flags;
    logic busy;
    logic [CNT_W-1:0] cnt0, cnt1;

    always #5 clk = ~clk;

    alu_arbiter #(.CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_opcode(req0_opcode),
        .req0_a(req0_a), .req0_b(req0_b),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_opcode(req1_opcode),
        .req1_a(req1_a), .req1_b(req1_b),
        .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
        .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
        .rsp_data(rsp_data), .rsp_flags(rsp_flags), .rsp_err(rsp_err),
        .alu_a(alu_a), .alu_b(alu_b), .alu_opcode(alu_opcode), .alu_enable(alu_enable),
        .alu_result(alu_result), .alu_flags(alu_flags),
        .busy(busy), .cnt0(cnt0), .cnt1(cnt1)
    );

    // External ALU: returns {zero, negative, carry, overflow, result}
    function automatic logic [7:0] alu_fn(input logic [3:0] op, input logic [3:0] a,
                                          input logic [3:0] b);
        logic [4:0] s;
        logic [3:0] r;
        logic c, v;
        s = 5'd0; r = 4'd0; c = 1'b0; v = 1'b0;
        case (op)
            4'd0: begin s = {1'b0, a} + {1'b0, b}; r = s[3:0]; c = s[4];
                        v = (a[3] == b[3]) && (r[3] != a[3]); end
            4'd1: begin s = {1'b0, a} + {1'b0, ~b} + 5'd1; r = s[3:0]; c = s[4];
                        v = (a[3] != b[3]) && (r[3] != a[3]); end
            4'd2: begin s = {1'b0, a} + 5'd1; r = s[3:0]; c = s[4]; v = (a == 4'h7); end
            4'd3: begin s = {1'b0, a} + 5'h0F; r = s[3:0]; c = s[4]; v = (a == 4'h8); end
            4'd4: r = a & b;
            4'd5: r = a | b;
            4'd6: r = a ^ b;
            4'd7: r = ~a;
            4'd8: r = a << b;
            4'd9: r = a >> b;
            4'd10: r = $signed(a) >>> b;
            default: return {4'b0110, 4'h5};
        endcase
        return {(r == 4'd0), r[3], c, v, r};
    endfunction

    assign {alu_flags, alu_result} = alu_fn(alu_opcode, alu_a, alu_b);

    typedef struct {
        int         id;
        logic [3:0] op, a, b, data, flags;
        logic       err;
    } vec_t;

    typedef struct {
        int         id;
        logic [3:0] data, flags;
        logic       err;
    } exp_t;

    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];
    int   acc_log[$];
    int   exp_cnt[2];
    bit   pend[2];
    bit   done = 1'b0;
    vec_t tbl[14];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic retire(input int n);
        exp_t e;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_rsp%0d actual=valid required=none", n);
        end else begin
            e = sb.pop_front();
            check("rsp_id", 32'(n), 32'(e.id));
            check("rsp_data", 32'(rsp_data), 32'(e.data));
            check("rsp_flags", 32'(rsp_flags), 32'(e.flags));
            check("rsp_err", 32'(rsp_err), 32'(e.err));
            exp_cnt[n] = (exp_cnt[n] == (1 << CNT_W) - 1) ? exp_cnt[n] : exp_cnt[n] + 1;
            pend[n] = 1'b1;
        end
    endtask

    task automatic issue(input int id, input logic [3:0] op, input logic [3:0] a,
                         input logic [3:0] b, input logic [3:0] ed, input logic [3:0] ef,
                         input logic ee);
        bit ok;
        ok = 1'b0;
        @(posedge clk); #1;
        if (id == 0) begin req0_valid = 1'b1; req0_opcode = op; req0_a = a; req0_b = b; end
        else         begin req1_valid = 1'b1; req1_opcode = op; req1_a = a; req1_b = b; end
        for (int n = 0; n < 60 && !ok; n++) begin
            @(negedge clk);
            if ((id == 0) ? req0_ready : req1_ready) ok = 1'b1;
        end
        if (ok) begin
            sb.push_back('{id, ed, ef, ee});
            acc_log.push_back(id);
        end else begin
            checks++;
            errors++;
            $display("FAIL accept_timeout%0d actual=no_ready required=ready", id);
        end
        @(posedge clk); #1;
        // Scramble the request so any late sampling corrupts the result
        if (id == 0) begin req0_valid = 1'b0; req0_opcode = 4'hF; req0_a = ~a; req0_b = ~b; end
        else         begin req1_valid = 1'b0; req1_opcode = 4'hF; req1_a = ~a; req1_b = ~b; end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout actual=%0d required=0", sb.size());
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic wait_rsp0();
        bit seen;
        seen = 1'b0;
        for (int n = 0; n < 10 && !seen; n++) begin
            @(negedge clk);
            if (rsp0_valid) seen = 1'b1;
        end
        check("rsp0_arrives", 32'(seen), 32'h1);
    endtask

    task automatic pulse_reset();
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
    endtask

    task automatic check_log(input int exp_log[$]);
        check("arb_log_len", 32'(acc_log.size()), 32'(exp_log.size()));
        for (int i = 0; i < exp_log.size() && i < acc_log.size(); i++)
            check("arb_order", 32'(acc_log[i]), 32'(exp_log[i]));
    endtask

    task automatic main_flow();
        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_outputs",
              32'({busy, rsp0_valid, rsp1_valid, rsp_data, rsp_flags, rsp_err, alu_enable,
                   alu_a, alu_b, alu_opcode, cnt0, cnt1, req0_ready, req1_ready}), 32'h0);
        @(posedge clk); #1 rst = 1'b0;

        // Single ADD with exact cycle timing
        req0_valid = 1'b1; req0_opcode = 4'd0; req0_a = 4'h7; req0_b = 4'h1;
        @(negedge clk);
        check("accept_T", 32'({req0_ready, req1_ready, busy}), 32'b100);
        sb.push_back('{0, 4'h8, 4'h5, 1'b0});
        @(posedge clk); #1 req0_valid = 1'b0; req0_a = 4'h3; req0_b = 4'h9;
        @(negedge clk);
        check("issue_T1", 32'({alu_enable, alu_a, alu_b, alu_opcode, busy, rsp0_valid}),
              32'({1'b1, 4'h7, 4'h1, 4'h0, 1'b1, 1'b0}));
        @(negedge clk);
        check("rsp_T2", 32'({rsp0_valid, rsp1_valid}), 32'b10);
        @(negedge clk);
        check("idle_T3", 32'(busy), 32'h0);

        // Contention from reset, then pointer return, then pointer on req1
        pulse_reset();
        acc_log.delete();
        fork
            issue(0, 4'd1, 4'h3, 4'h5, 4'hE, 4'b0100, 1'b0);
            issue(1, 4'd4, 4'hF, 4'hA, 4'hA, 4'b0100, 1'b0);
        join
        drain();
        fork
            issue(0, 4'd1, 4'h8, 4'h1, 4'h7, 4'b0011, 1'b0);
            issue(1, 4'd6, 4'h5, 4'h5, 4'h0, 4'b1000, 1'b0);
        join
        drain();
        issue(0, 4'd9, 4'h8, 4'h1, 4'h4, 4'b0000, 1'b0);
        drain();
        fork
            issue(0, 4'd7, 4'h3, 4'h0, 4'hC, 4'b0100, 1'b0);
            issue(1, 4'd8, 4'h3, 4'h1, 4'h6, 4'b0000, 1'b0);
        join
        drain();
        check_log('{0, 1, 0, 1, 0, 1, 0});

        // Back-pressure on rsp0 with a waiting req1 and a stray rsp1_ready
        rsp0_ready = 1'b0;
        rsp1_ready = 1'b0;
        fork
            issue(0, 4'd0, 4'h2, 4'h3, 4'h5, 4'b0000, 1'b0);
            begin
                @(posedge clk);
                issue(1, 4'd5, 4'h0, 4'h0, 4'h0, 4'b1000, 1'b0);
            end
            begin
                wait_rsp0();
                for (int i = 0; i < 5; i++) begin
                    check("hold_state",
                          32'({rsp0_valid, rsp1_valid, rsp_data, rsp_flags, rsp_err, req1_ready}),
                          32'({1'b1, 1'b0, 4'h5, 4'h0, 1'b0, 1'b0}));
                    @(posedge clk); #1 rsp1_ready = (i == 1);
                    @(negedge clk);
                end
                @(posedge clk); #1 rsp0_ready = 1'b1; rsp1_ready = 1'b1;
            end
        join
        drain();

        // Reset while a response is pending abandons it
        rsp0_ready = 1'b0;
        issue(0, 4'd1, 4'h3, 4'h5, 4'hE, 4'b0100, 1'b0);
        wait_rsp0();
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        check("rst_in_resp", 32'({rsp0_valid, rsp1_valid, busy, cnt0, cnt1}), 32'h0);
        rsp0_ready = 1'b1;
        acc_log.delete();
        fork
            issue(0, 4'd2, 4'h7, 4'h0, 4'h8, 4'b0101, 1'b0);
            issue(1, 4'd3, 4'h8, 4'h0, 4'h7, 4'b0011, 1'b0);
        join
        drain();
        check_log('{0, 1});

        // Vector table, served back to back
        for (int i = 0; i < 14; i++)
            issue(tbl[i].id, tbl[i].op, tbl[i].a, tbl[i].b,
                  tbl[i].data, tbl[i].flags, tbl[i].err);
        drain();
        check("cnt0_saturated", 32'(cnt0), 32'h3);
        check("cnt1_saturated", 32'(cnt1), 32'h3);
        done = 1'b1;
    endtask

    initial begin
        tbl[0]  = '{1, 4'd12, 4'h3, 4'h4, 4'h0, 4'b1000, 1'b1};
        tbl[1]  = '{0, 4'd0,  4'h7, 4'h1, 4'h8, 4'b0101, 1'b0};
        tbl[2]  = '{0, 4'd1,  4'h8, 4'h1, 4'h7, 4'b0011, 1'b0};
        tbl[3]  = '{1, 4'd2,  4'hF, 4'h0, 4'h0, 4'b1010, 1'b0};
        tbl[4]  = '{0, 4'd3,  4'h0, 4'h0, 4'hF, 4'b0100, 1'b0};
        tbl[5]  = '{0, 4'd6,  4'h5, 4'h5, 4'h0, 4'b1000, 1'b0};
        tbl[6]  = '{1, 4'd7,  4'h3, 4'h0, 4'hC, 4'b0100, 1'b0};
        tbl[7]  = '{0, 4'd8,  4'h3, 4'h1, 4'h6, 4'b0000, 1'b0};
        tbl[8]  = '{0, 4'd10, 4'h8, 4'h1, 4'hC, 4'b0100, 1'b0};
        tbl[9]  = '{1, 4'd9,  4'h8, 4'h1, 4'h4, 4'b0000, 1'b0};
        tbl[10] = '{0, 4'd5,  4'h0, 4'h0, 4'h0, 4'b1000, 1'b0};
        tbl[11] = '{0, 4'd15, 4'hF, 4'hF, 4'h0, 4'b1000, 1'b1};
        tbl[12] = '{1, 4'd4,  4'hF, 4'hA, 4'hA, 4'b0100, 1'b0};
        tbl[13] = '{0, 4'd2,  4'h7, 4'h0, 4'h8, 4'b0101, 1'b0};
        exp_cnt[0] = 0;
        exp_cnt[1] = 0;
        pend[0] = 1'b0;
        pend[1] = 1'b0;
        fork
            main_flow();
            begin
                while (!done) begin
                    @(negedge clk);
                    if (rst) begin
                        sb.delete();
                        exp_cnt[0] = 0;
                        exp_cnt[1] = 0;
                        pend[0] = 1'b0;
                        pend[1] = 1'b0;
                    end else begin
                        if (pend[0]) begin check("cnt0", 32'(cnt0), 32'(exp_cnt[0])); pend[0] = 1'b0; end
                        if (pend[1]) begin check("cnt1", 32'(cnt1), 32'(exp_cnt[1])); pend[1] = 1'b0; end
                        if (!alu_enable)
                            check("alu_idle", 32'({alu_a, alu_b, alu_opcode}), 32'h0);
                        if (rsp0_valid || rsp1_valid)
                            check("rsp_onehot", 32'(rsp0_valid & rsp1_valid), 32'h0);
                        if (rsp0_valid && rsp0_ready) retire(0);
                        if (rsp1_valid && rsp1_ready) retire(1);
                    end
                end
            end
        join
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
